// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter front-end control stage.
package counter_ctrl_pkg;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_AUTO   = 1'b1
   } mode_e;

   localparam int unsigned SYNC_STAGES       = 2;
   localparam int unsigned REPEAT_HOLD_TICKS = 8;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: synchroniser, stability counter and press-edge pulse.
module btn_debounce
   import counter_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
)
(
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_db,
   output logic press_pulse
);

   localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q;
   logic                   btn_sync;
   logic                   flip;

   assign btn_sync = sync_q[SYNC_STAGES-1];
   assign flip     = (btn_sync != btn_db) && (cnt_q == CNT_MAX);

   // press_pulse is raised on the same edge the debounced state rises
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q      <= '0;
         cnt_q       <= '0;
         btn_db      <= 1'b0;
         press_pulse <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], btn_raw};
         press_pulse <= flip & btn_sync;
         if (btn_sync == btn_db) begin
            cnt_q <= '0;
         end else if (flip) begin
            cnt_q  <= '0;
            btn_db <= btn_sync;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/counter_ctrl.sv
// Drives the loadable counter's ld/en/ld_val from buttons, with MANUAL/AUTO modes.
// Optional step auto-repeat in MANUAL mode: define COUNTER_CTRL_AUTOREPEAT_EN.
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W           = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned TICK_DIV        = 50000000
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_load,
   input  logic             btn_step,
   input  logic             btn_mode,
   input  logic [CNT_W-1:0] sw_val,
   output logic             ld,
   output logic             en,
   output logic [CNT_W-1:0] ld_val,
   output logic             mode_auto
);

   localparam int unsigned   PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   logic load_p, step_p, mode_p;
   logic load_db, step_db, mode_db;

   logic [CNT_W-1:0] sw_sync_q [SYNC_STAGES];

   mode_e            state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d, presc_inc;
   logic             tick;
   logic             ld_d, en_d;
   logic [CNT_W-1:0] ld_val_d;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
      .clk(clk), .rst(rst), .btn_raw(btn_load), .btn_db(load_db), .press_pulse(load_p)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
      .clk(clk), .rst(rst), .btn_raw(btn_step), .btn_db(step_db), .press_pulse(step_p)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .clk(clk), .rst(rst), .btn_raw(btn_mode), .btn_db(mode_db), .press_pulse(mode_p)
   );

`ifdef COUNTER_CTRL_AUTOREPEAT_EN
   localparam int unsigned       HOLD_W   = $clog2(REPEAT_HOLD_TICKS);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(REPEAT_HOLD_TICKS - 1);

   logic              rep_arm_q, rep_arm_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              unused_db;
   assign unused_db = ^{load_db, mode_db};
`else
   logic              unused_db;
   assign unused_db = ^{load_db, step_db, mode_db};
`endif

   assign tick      = (presc_q == PRESC_MAX);
   assign presc_inc = tick ? '0 : presc_q + PW'(1);

   // Next-state and output decode; load wins over a same-cycle increment
   always_comb begin
      state_d  = state_q;
      presc_d  = '0;
      ld_d     = 1'b0;
      en_d     = 1'b0;
      ld_val_d = ld_val;
`ifdef COUNTER_CTRL_AUTOREPEAT_EN
      rep_arm_d = rep_arm_q;
      hold_d    = hold_q;
`endif

      if (mode_p) begin
         state_d = (state_q == MODE_AUTO) ? MODE_MANUAL : MODE_AUTO;
      end

      if (state_q == MODE_MANUAL) begin
         en_d = step_p;
      end else begin
         en_d = tick;
      end

      if ((state_q == MODE_AUTO) && (state_d == MODE_AUTO)) begin
         presc_d = presc_inc;
      end

`ifdef COUNTER_CTRL_AUTOREPEAT_EN
      // Repeat arms on a MANUAL step press and dies on release or mode change
      if ((state_q == MODE_MANUAL) && !mode_p) begin
         if (step_p) begin
            rep_arm_d = 1'b1;
            hold_d    = '0;
         end else if (!step_db) begin
            rep_arm_d = 1'b0;
            hold_d    = '0;
         end else if (rep_arm_q) begin
            presc_d = presc_inc;
            if (tick) begin
               if (hold_q == HOLD_MAX) begin
                  en_d = 1'b1;
               end else begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
         end
      end else begin
         rep_arm_d = 1'b0;
         hold_d    = '0;
      end
`endif

      if (load_p) begin
         ld_d     = 1'b1;
         en_d     = 1'b0;
         ld_val_d = sw_sync_q[SYNC_STAGES-1];
         presc_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) begin
            sw_sync_q[i] <= '0;
         end
         state_q   <= MODE_MANUAL;
         presc_q   <= '0;
         ld        <= 1'b0;
         en        <= 1'b0;
         ld_val    <= '0;
         mode_auto <= 1'b0;
`ifdef COUNTER_CTRL_AUTOREPEAT_EN
         rep_arm_q <= 1'b0;
         hold_q    <= '0;
`endif
      end else begin
         sw_sync_q[0] <= sw_val;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sw_sync_q[i] <= sw_sync_q[i-1];
         end
         state_q   <= state_d;
         presc_q   <= presc_d;
         ld        <= ld_d;
         en        <= en_d;
         ld_val    <= ld_val_d;
         mode_auto <= (state_d == MODE_AUTO);
`ifdef COUNTER_CTRL_AUTOREPEAT_EN
         rep_arm_q <= rep_arm_d;
         hold_q    <= hold_d;
`endif
      end
   end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=5.
module tb_counter_ctrl;

   localparam int unsigned CNT_W = 3;
   localparam int unsigned DB    = 4;
   localparam int unsigned TD    = 5;

`ifdef COUNTER_CTRL_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic             clk      = 1'b0;
   logic             rst      = 1'b1;
   logic             btn_load = 1'b0;
   logic             btn_step = 1'b0;
   logic             btn_mode = 1'b0;
   logic [CNT_W-1:0] sw_val   = '0;
   logic             ld, en, mode_auto;
   logic [CNT_W-1:0] ld_val;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic             btn_load;
      logic [CNT_W-1:0] sw;
      logic             exp_ld;
      logic             exp_en;
      logic [CNT_W-1:0] exp_ld_val;
      logic             exp_mode;
   } vec_t;

   counter_ctrl #(.CNT_W(CNT_W), .DEBOUNCE_CYCLES(DB), .TICK_DIV(TD)) dut (
      .clk(clk), .rst(rst), .btn_load(btn_load), .btn_step(btn_step),
      .btn_mode(btn_mode), .sw_val(sw_val), .ld(ld), .en(en),
      .ld_val(ld_val), .mode_auto(mode_auto)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end

   function automatic logic [5:0] outs(input logic l, input logic e,
                                       input logic [2:0] v, input logic m);
      return {l, e, v, m};
   endfunction

   task automatic chk(input string name, input int k, input logic [5:0] exp);
      logic [5:0] got;
      got = {ld, en, ld_val, mode_auto};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s k=%0d got {ld,en,ld_val,mode_auto}=%b expected %b",
                  name, k, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t vecs [14];
      logic exp_en;

      // Load press held from edge 1: ld after edge 7 only, switches change after capture
      for (int i = 0; i < 14; i++) begin
         vecs[i] = '{btn_load: 1'b1, sw: (i < 9) ? 3'd5 : 3'd3,
                     exp_ld: (i == 6), exp_en: 1'b0,
                     exp_ld_val: (i >= 6) ? 3'd5 : 3'd0, exp_mode: 1'b0};
      end

      repeat (2) @(posedge clk);
      #1;
      chk("reset", 0, outs(1'b0, 1'b0, 3'd0, 1'b0));
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         btn_load = vecs[i].btn_load;
         sw_val   = vecs[i].sw;
         cyc();
         chk("load_vec", i + 1, outs(vecs[i].exp_ld, vecs[i].exp_en,
                                     vecs[i].exp_ld_val, vecs[i].exp_mode));
      end

      // 3-cycle step glitch is rejected
      for (int c = 0; c < 6; c++) begin
         btn_step = (c < 3);
         cyc();
         chk("step_glitch", c + 1, outs(1'b0, 1'b0, 3'd5, 1'b0));
      end

      // Steady step press: one en after edge 7
      for (int k = 1; k <= 12; k++) begin
         btn_step = 1'b1;
         cyc();
         chk("step_press", k, outs(1'b0, (k == 7), 3'd5, 1'b0));
      end

      // Mode press into AUTO, step re-press ignored, load lands on a tick cycle
      for (int k = 1; k <= 48; k++) begin
         btn_mode = 1'b1;
         btn_load = (k >= 31);
         btn_step = (k >= 10);
         if (k >= 20) sw_val = 3'd2;
         cyc();
         exp_en = (k >= 12) && (((k - 12) % 5) == 0) && (k != 37);
         chk("auto_run", k, outs((k == 37), exp_en, (k >= 37) ? 3'd2 : 3'd5, (k >= 7)));
      end

      // Asynchronous reset mid AUTO run clears outputs before any edge
      btn_load = 1'b0;
      btn_mode = 1'b0;
      rst      = 1'b1;
      #1;
      chk("rst_async", 0, outs(1'b0, 1'b0, 3'd0, 1'b0));
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_hold", 0, outs(1'b0, 1'b0, 3'd0, 1'b0));
      rst = 1'b0;

      // Step held through reset is a fresh press; long hold repeats only with auto-repeat
      for (int k = 1; k <= 100; k++) begin
         btn_step = (k <= 80);
         cyc();
         exp_en = (k == 7) || (AR && (k >= 47) && (k <= 82) && (((k - 47) % 5) == 0));
         chk("post_rst_hold", k, outs(1'b0, exp_en, 3'd0, 1'b0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
